// File: rtl/alu_seq_pkg.sv
// Shared definitions for the handshaked sequential ALU: opcodes, flag bit
// positions and controller states.
package alu_seq_pkg;

    localparam int OP_W = 4;
    typedef logic [OP_W-1:0] bit_op_t;

    localparam bit_op_t OP_INV  = 4'd0;
    localparam bit_op_t OP_AND  = 4'd1;
    localparam bit_op_t OP_OR   = 4'd2;
    localparam bit_op_t OP_XOR  = 4'd3;
    localparam bit_op_t OP_XNOR = 4'd4;
    localparam bit_op_t OP_COM  = 4'd5;
    localparam bit_op_t OP_SHR  = 4'd6;
    localparam bit_op_t OP_SHL  = 4'd7;
    localparam bit_op_t OP_ADD  = 4'd8;
    localparam bit_op_t OP_SUB  = 4'd9;
    localparam bit_op_t OP_MUL  = 4'd10;
    localparam bit_op_t OP_DIV  = 4'd11;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ERR   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_div_iter.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// quotient/remainder carry the final result during the cycle done is high.
module alu_div_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic [CNT_W-1:0] count;
    logic             busy_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    // A borrow out of the trial subtraction means the divisor did not fit.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, div_q};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    assign busy      = busy_q;
    assign done      = busy_q && (count == '0);
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            count  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            div_q  <= divisor;
            count  <= CNT_W'(WIDTH - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            if (count == '0) begin
                busy_q <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops finish on the accept edge, DIV runs the
// iterative divider; the result is held until the consumer takes it.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SHAMT_W    = 4,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  bit_op_t          alu_op,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_hi,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t             state;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [3:0]         res_flags;
    logic               carry;
    logic               ovf;
    logic               err;
    logic               lt;
    logic               eq;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     difference;
    logic [2*WIDTH-1:0] prod;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign div_start = (state == ST_IDLE) && in_valid && (alu_op == OP_DIV) && (din1 != '0);

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (din0),
        .divisor   (din1),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Single-cycle datapath; the DIV arm only covers the divide-by-zero case.
    always_comb begin
        res_lo     = '0;
        res_hi     = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        err        = 1'b0;
        sum        = {1'b0, din0} + {1'b0, din1};
        difference = {1'b0, din0} - {1'b0, din1};
        prod       = {{WIDTH{1'b0}}, din0} * {{WIDTH{1'b0}}, din1};
        lt         = SIGNED_CMP ? ($signed(din0) < $signed(din1)) : (din0 < din1);
        eq         = (din0 == din1);
        case (alu_op)
            OP_INV:  res_lo = ~din0;
            OP_AND:  res_lo = din0 & din1;
            OP_OR:   res_lo = din0 | din1;
            OP_XOR:  res_lo = din0 ^ din1;
            OP_XNOR: res_lo = ~(din0 ^ din1);
            OP_COM:  res_lo = {{(WIDTH-3){1'b0}}, ~lt & ~eq, eq, lt};
            OP_SHR:  res_lo = $signed(din0) >>> din1[SHAMT_W-1:0];
            OP_SHL:  res_lo = din0 << din1[SHAMT_W-1:0];
            OP_ADD: begin
                res_lo = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (din0[WIDTH-1] == din1[WIDTH-1]) && (sum[WIDTH-1] != din0[WIDTH-1]);
            end
            OP_SUB: begin
                res_lo = difference[WIDTH-1:0];
                carry  = difference[WIDTH];
                ovf    = (din0[WIDTH-1] != din1[WIDTH-1]) && (difference[WIDTH-1] != din0[WIDTH-1]);
            end
            OP_MUL: begin
                res_lo = prod[WIDTH-1:0];
                res_hi = prod[2*WIDTH-1:WIDTH];
                ovf    = (prod[2*WIDTH-1:WIDTH] != '0);
            end
            OP_DIV: begin
                res_lo = '1;
                res_hi = din0;
                err    = 1'b1;
            end
            default: err = 1'b1;
        endcase
        res_flags            = '0;
        res_flags[FLAG_ZERO]  = (res_lo == '0);
        res_flags[FLAG_CARRY] = carry;
        res_flags[FLAG_OVF]   = ovf;
        res_flags[FLAG_ERR]   = err;
    end

    // Controller and output register; a lost divider drops back to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            dout    <= '0;
            dout_hi <= '0;
            flags   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        state <= ST_BUSY;
                    end else if (in_valid) begin
                        dout    <= res_lo;
                        dout_hi <= res_hi;
                        flags   <= res_flags;
                        state   <= ST_DONE;
                    end
                end
                ST_BUSY: begin
                    if (div_done) begin
                        dout    <= div_quo;
                        dout_hi <= div_rem;
                        flags   <= {3'b000, div_quo == '0};
                        state   <= ST_DONE;
                    end else if (!div_busy) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq; a second instance with signed
// compare shares the stimulus so both COM flavours are observed.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  fl;
        int          lat;
    } want_t;

    logic        clock;
    logic        reset;
    logic [3:0]  alu_op;
    logic [15:0] din0;
    logic [15:0] din1;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready;
    logic [15:0] dout;
    logic [15:0] dout_hi;
    logic [3:0]  flags;
    logic        out_valid;
    logic        s_in_ready;
    logic [15:0] s_dout;
    logic [15:0] s_dout_hi;
    logic [3:0]  s_flags;
    logic        s_out_valid;

    want_t sb[$];
    int    compared;
    int    mismatched;

    alu_seq #(.WIDTH(16), .SHAMT_W(4), .SIGNED_CMP(1'b0)) dut (
        .clock(clock), .reset(reset), .alu_op(alu_op), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .dout_hi(dout_hi),
        .flags(flags), .out_valid(out_valid), .out_ready(out_ready)
    );

    alu_seq #(.WIDTH(16), .SHAMT_W(4), .SIGNED_CMP(1'b1)) dut_s (
        .clock(clock), .reset(reset), .alu_op(alu_op), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_ready(s_in_ready), .dout(s_dout), .dout_hi(s_dout_hi),
        .flags(s_flags), .out_valid(s_out_valid), .out_ready(out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Pops the oldest expectation and compares it with the held result.
    task automatic check_output(input int cycles, input bit saw_ready);
        want_t w;
        check_value("scoreboard not empty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            w = sb.pop_front();
            check_value({w.tag, " out_valid"}, 32'(out_valid), 32'd1);
            check_value({w.tag, " latency"}, 32'(cycles), 32'(w.lat));
            check_value({w.tag, " dout"}, 32'(dout), 32'(w.lo));
            check_value({w.tag, " dout_hi"}, 32'(dout_hi), 32'(w.hi));
            check_value({w.tag, " flags"}, 32'(flags), 32'(w.fl));
            check_value({w.tag, " in_ready low while pending"}, 32'(saw_ready), 32'd0);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input string tag, input logic [15:0] lo, input logic [15:0] hi,
                                  input logic [3:0] fl, input int lat, input bit scramble);
        int cycles;
        bit saw_ready;
        sb.push_back('{tag, lo, hi, fl, lat});
        check_value({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        alu_op   = op;
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        cycles    = 1;
        saw_ready = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (in_ready) saw_ready = 1'b1;
            if (scramble) begin
                din0   = 16'($urandom);
                din1   = 16'($urandom);
                alu_op = 4'($urandom_range(0, 15));
            end
            @(posedge clock); #1;
            cycles++;
        end
        check_output(cycles, saw_ready);
    endtask

    task automatic retire(input string tag);
        @(posedge clock); #1;
        check_value({tag, " retire out_valid"}, 32'(out_valid), 32'd0);
        check_value({tag, " retire in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        alu_op     = OP_INV;
        din0       = '0;
        din1       = '0;
        repeat (3) @(posedge clock);
        #1;
        check_value("reset in_ready", 32'(in_ready), 32'd1);
        check_value("reset out_valid", 32'(out_valid), 32'd0);
        check_value("reset dout", 32'(dout), 32'd0);
        check_value("reset dout_hi", 32'(dout_hi), 32'd0);
        check_value("reset flags", 32'(flags), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        apply_stimulus(OP_ADD, 16'hFFFF, 16'h0001, "ADD wrap", 16'h0000, 16'h0000, 4'b0011, 1, 1'b0);
        retire("ADD");
        apply_stimulus(OP_SUB, 16'h8000, 16'h0001, "SUB ovf", 16'h7FFF, 16'h0000, 4'b0100, 1, 1'b0);
        retire("SUB");
        apply_stimulus(OP_COM, 16'h0003, 16'hFFFF, "COM unsigned", 16'h0001, 16'h0000, 4'b0000, 1, 1'b0);
        check_value("COM signed dout", 32'(s_dout), 32'h0004);
        check_value("COM signed dout_hi", 32'(s_dout_hi), 32'h0000);
        check_value("COM signed flags", 32'(s_flags), 32'h0);
        check_value("COM signed out_valid", 32'(s_out_valid), 32'd1);
        check_value("COM signed in_ready", 32'(s_in_ready), 32'd0);
        retire("COM");
        apply_stimulus(OP_MUL, 16'h1234, 16'h0100, "MUL", 16'h3400, 16'h0012, 4'b0100, 1, 1'b0);
        retire("MUL");
        apply_stimulus(OP_SHR, 16'h8000, 16'h0003, "SHR", 16'hF000, 16'h0000, 4'b0000, 1, 1'b0);
        retire("SHR");
        apply_stimulus(OP_SHL, 16'h0001, 16'h000F, "SHL", 16'h8000, 16'h0000, 4'b0000, 1, 1'b0);
        retire("SHL");
        apply_stimulus(OP_XNOR, 16'hF0F0, 16'hFF00, "XNOR", 16'hF00F, 16'h0000, 4'b0000, 1, 1'b0);
        retire("XNOR");
        apply_stimulus(OP_INV, 16'h00FF, 16'h1234, "INV", 16'hFF00, 16'h0000, 4'b0000, 1, 1'b0);
        retire("INV");
        apply_stimulus(OP_DIV, 16'd100, 16'd7, "DIV 100/7", 16'd14, 16'd2, 4'b0000, 17, 1'b1);
        retire("DIV");
        apply_stimulus(OP_DIV, 16'h1234, 16'h0000, "DIV by zero", 16'hFFFF, 16'h1234, 4'b1000, 1, 1'b0);
        retire("DIV0");
        apply_stimulus(4'hF, 16'h5555, 16'hAAAA, "illegal op", 16'h0000, 16'h0000, 4'b1001, 1, 1'b0);
        retire("ILL");

        // Back-pressure: result must hold while a competing request waits.
        out_ready = 1'b0;
        apply_stimulus(OP_XOR, 16'h00FF, 16'h0F0F, "XOR held", 16'h0FF0, 16'h0000, 4'b0000, 1, 1'b0);
        alu_op   = OP_AND;
        din0     = 16'h0F0F;
        din1     = 16'h00FF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check_value("hold out_valid", 32'(out_valid), 32'd1);
            check_value("hold dout", 32'(dout), 32'h0FF0);
            check_value("hold flags", 32'(flags), 32'h0);
        end
        sb.push_back('{"AND after retire", 16'h000F, 16'h0000, 4'b0000, 1});
        out_ready = 1'b1;
        @(posedge clock); #1;
        check_value("retire edge out_valid", 32'(out_valid), 32'd0);
        check_value("retire edge in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check_output(1, 1'b0);
        retire("AND");

        // Reset in the sixth cycle of a division abandons it.
        alu_op   = OP_DIV;
        din0     = 16'd1000;
        din1     = 16'd3;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check_value("mid-DIV in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_value("abort out_valid", 32'(out_valid), 32'd0);
        check_value("abort dout", 32'(dout), 32'd0);
        check_value("abort flags", 32'(flags), 32'd0);
        check_value("abort in_ready", 32'(in_ready), 32'd1);
        apply_stimulus(OP_ADD, 16'h0002, 16'h0003, "ADD after abort", 16'h0005, 16'h0000, 4'b0000, 1, 1'b0);
        retire("ADD2");

        check_value("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU; sits between the register-file read stage and writeback.
- Generalised data width.
- Adds the following:
  - valid/ready handshaking
  - a multi-cycle restoring divider with remainder
  - a full-width multiply high half
  - status flags
  - illegal-opcode and divide-by-zero reporting
- Single-cycle ops complete in 1 cycle; DIV iterates one quotient bit per cycle.

Parameters:
- WIDTH, 16, operand/result width (≥4).
- SHAMT_W, 4, shift-amount bits taken from din1[SHAMT_W-1:0]; must equal clog2(WIDTH).
- SIGNED_CMP, 0, 1 = COM compares operands as two's complement; 0 = unsigned.

Ports:
- clock       input   1        rising-edge clock
- reset       input   1        synchronous, active-high reset
- alu_op      input   `BIT_OP  opcode, sampled on accept
- din0        input   WIDTH    operand A
- din1        input   WIDTH    operand B / shift amount
- in_valid    input   1        request valid
- in_ready    output  1        block can accept request
- dout        output  WIDTH    result (quotient for DIV, low half for MUL)
- dout_hi     output  WIDTH    MUL high half / DIV remainder; 0 for other ops
- flags       output  4        {err, ovf, carry, zero}
- out_valid   output  1        result valid
- out_ready   input   1        consumer takes result

Behaviour:
- Reset:
  - Reset is synchronous and active-high on clock; it overrides everything, including an in-flight DIV, which is abandoned.
  - After reset: state IDLE, dout=0, dout_hi=0, flags=0, out_valid=0, in_ready=1.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid=1. Operands and opcode are latched.
  - Non-DIV op: result is registered that edge; next state DONE (latency 1).
  - DIV with din1≠0: next state BUSY, counter=WIDTH-1.
- BUSY:
  - in_ready=0.
  - One restoring-division step per cycle, MSB first.
  - When counter reaches 0: write quotient/remainder, go to DONE. DIV latency = WIDTH+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1, in_ready=0.
  - dout, dout_hi and flags hold stable until out_ready=1; then next state IDLE.
  - No back-to-back accept on the same edge; throughput is at most 1 op per 2 cycles.
- Ops (encodings in the shared definitions file):
  - INV: ~A.
  - AND, OR, XOR, XNOR: bitwise.
  - COM: dout[0]=A<B, dout[1]=A==B, dout[2]=A>B; other bits 0. Signedness per SIGNED_CMP.
  - SHR: arithmetic right shift by din1[SHAMT_W-1:0].
  - SHL: logical left shift by din1[SHAMT_W-1:0].
  - ADD: A+B mod 2^WIDTH. carry = bit WIDTH; ovf = signed overflow.
  - SUB: A-B. carry = borrow (A<B unsigned); ovf = signed overflow.
  - MUL: unsigned 2·WIDTH product, {dout_hi,dout}. ovf = (dout_hi≠0).
- Flags:
  - zero = (dout==0) for every op.
  - carry and ovf are 0 for ops not listed above.
- DIV by zero:
  - No iteration; latency 1.
  - dout = all ones, dout_hi = A, err=1.
- Illegal opcode:
  - Latency 1; dout=0, dout_hi=0, err=1, zero=1.
- Inputs and handshake:
  - Operand inputs are ignored while in_ready=0; changing them mid-DIV has no effect.
  - in_valid and out_ready asserted together in DONE: the result retires; the new request is not accepted until the next IDLE cycle.

Decomposition:
- Shared definitions include file holds:
  - `BIT_OP
  - opcode macros INV, AND, OR, XOR, XNOR, COM, SHR, SHL, ADD, SUB, MUL, DIV
  - flag bit indices FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVF=2, FLAG_ERR=3
  - FSM state encodings
- One sub-module, alu_div_iter:
  - restoring divider with start/busy/done, WIDTH-parameterised
  - outputs quotient and remainder
  - synchronous reset
- alu_seq owns the FSM, single-cycle datapath and output register.

Test Plan:
- Reset released, WIDTH=16, ADD 0xFFFF+0x0001 with out_ready=1 → out_valid 1 cycle after accept; dout=0x0000, flags zero=1, carry=1, ovf=0; in_ready=1 the following cycle.
- SUB 0x8000−0x0001 → dout=0x7FFF, ovf=1, carry=0. COM 0x0003 vs 0xFFFF with SIGNED_CMP=1 → dout=0x0004 (gt); with SIGNED_CMP=0 → dout=0x0001 (lt).
- MUL 0x1234×0x0100 → dout=0x3400, dout_hi=0x0012, ovf=1. SHR 0x8000 by 3 → 0xF000. SHL 0x0001 by 15 → 0x8000.
- DIV 100÷7 → out_valid exactly 17 cycles after accept; dout=14, dout_hi=2; in_ready=0 throughout. Operand changes during BUSY do not alter the result.
- DIV 0x1234÷0 → latency 1; dout=0xFFFF, dout_hi=0x1234, err=1. Illegal opcode → dout=0, err=1.
- Back-pressure and reset:
  - Hold out_ready=0 for 5 cycles after a result: outputs stable, in_valid ignored.
  - Assert reset on the 6th cycle of a DIV: next cycle out_valid=0, dout=0, flags=0, in_ready=1.
